// File: rtl/output_forward_mac_if.sv
// output_forward_mac_if: stream-in / replay-out bundle for the output-neuron
// forward accumulator.
//   master (producer side): drives start_i, valid_i, hidden_val_i, w_i, b_pass_i;
//                           observes busy_o, final_o, final_valid_o,
//                           hidden_val_o, hidden_idx_o, replay_valid_o.
//   slave  (accumulator):   the mirror image of master.
interface output_forward_mac_if #(
   parameter int unsigned IDX_W = 2
);
   localparam int unsigned HV_W  = 10;
   localparam int unsigned WT_W  = 8;
   localparam int unsigned ACC_W = 23;

   logic               start_i;
   logic               valid_i;
   logic [HV_W-1:0]    hidden_val_i;
   logic [WT_W-1:0]    w_i;
   logic               b_pass_i;
   logic               busy_o;
   logic [ACC_W-1:0]   final_o;
   logic               final_valid_o;
   logic [HV_W-1:0]    hidden_val_o;
   logic [IDX_W-1:0]   hidden_idx_o;
   logic               replay_valid_o;

   modport master (
      output start_i, valid_i, hidden_val_i, w_i, b_pass_i,
      input  busy_o, final_o, final_valid_o, hidden_val_o, hidden_idx_o, replay_valid_o
   );

   modport slave (
      input  start_i, valid_i, hidden_val_i, w_i, b_pass_i,
      output busy_o, final_o, final_valid_o, hidden_val_o, hidden_idx_o, replay_valid_o
   );
endinterface

// File: rtl/output_forward_mac.sv
// output_forward_mac: forward-pass accumulator for the output neuron.
// Accumulates final = sum(hidden_val * w) over N_HIDDEN streamed beats while
// keeping a copy of every activation, then replays those activations one per
// cycle when the backward pass is requested.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset, clears all state
//   bus    : output_forward_mac_if.slave
//            in : start_i, valid_i, hidden_val_i[9:0], w_i[7:0], b_pass_i
//            out: busy_o, final_o[22:0], final_valid_o, hidden_val_o[9:0],
//                 hidden_idx_o[IDX_W-1:0], replay_valid_o (all registered)
module output_forward_mac #(
   parameter int unsigned N_HIDDEN = 4,
   parameter int unsigned IDX_W    = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   output_forward_mac_if.slave  bus
);

   localparam int unsigned HV_W   = 10;
   localparam int unsigned WT_W   = 8;
   localparam int unsigned PROD_W = HV_W + WT_W;
   localparam int unsigned ACC_W  = 23;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HIDDEN - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_DONE   = 2'd2,
      S_REPLAY = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic [ACC_W-1:0]    acc;
   logic [IDX_W-1:0]    idx;
   logic [HV_W-1:0]     hidden_buf [N_HIDDEN];
   logic                replay_last;

   logic                busy;
   logic [ACC_W-1:0]    final_q;
   logic                final_valid;
   logic [HV_W-1:0]     hidden_val_q;
   logic [IDX_W-1:0]    hidden_idx_q;
   logic                replay_valid;

   logic                start_pass_c;
   logic                beat_c;
   logic                last_beat_c;
   logic                go_replay_c;
   logic                emit_c;
   logic                replay_end_c;
   logic [PROD_W-1:0]   prod_c;
   logic [ACC_W-1:0]    sum_c;

   // Product is at most 18 bits; zero-extend before adding to the 23-bit sum.
   assign prod_c = PROD_W'(bus.hidden_val_i) * PROD_W'(bus.w_i);
   assign sum_c  = acc + ACC_W'(prod_c);

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // Next-state and datapath strobes.
   always_comb begin
      state_nxt    = state;
      start_pass_c = 1'b0;
      beat_c       = 1'b0;
      last_beat_c  = 1'b0;
      go_replay_c  = 1'b0;
      emit_c       = 1'b0;
      replay_end_c = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start_i) begin
               start_pass_c = 1'b1;
               state_nxt    = S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (bus.valid_i) begin
               beat_c = 1'b1;
               if (idx == LAST_IDX) begin
                  last_beat_c = 1'b1;
                  state_nxt   = S_DONE;
               end
            end
         end
         S_DONE: begin
            // Backward request takes priority over a new forward pass.
            if (bus.b_pass_i) begin
               go_replay_c = 1'b1;
               state_nxt   = S_REPLAY;
            end else if (bus.start_i) begin
               start_pass_c = 1'b1;
               state_nxt    = S_ACCUM;
            end
         end
         S_REPLAY: begin
            // One extra cycle after the last entry lets replay_valid drop cleanly.
            if (replay_last) begin
               replay_end_c = 1'b1;
               state_nxt    = S_IDLE;
            end else begin
               emit_c = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Accumulator, activation buffer, and registered outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc          <= '0;
         idx          <= '0;
         replay_last  <= 1'b0;
         busy         <= 1'b0;
         final_q      <= '0;
         final_valid  <= 1'b0;
         hidden_val_q <= '0;
         hidden_idx_q <= '0;
         replay_valid <= 1'b0;
         for (int i = 0; i < int'(N_HIDDEN); i++) hidden_buf[i] <= '0;
      end else begin
         busy <= (state_nxt == S_ACCUM) || (state_nxt == S_REPLAY);

         if (start_pass_c) begin
            acc         <= '0;
            idx         <= '0;
            final_valid <= 1'b0;
         end

         if (beat_c) begin
            hidden_buf[idx] <= bus.hidden_val_i;
            if (last_beat_c) begin
               final_q     <= sum_c;
               final_valid <= 1'b1;
               acc         <= '0;
               idx         <= '0;
            end else begin
               acc <= sum_c;
               idx <= idx + IDX_W'(1);
            end
         end

         if (go_replay_c) begin
            idx         <= '0;
            replay_last <= 1'b0;
         end

         if (emit_c) begin
            hidden_val_q <= hidden_buf[idx];
            hidden_idx_q <= idx;
            replay_valid <= 1'b1;
            replay_last  <= (idx == LAST_IDX);
            idx          <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
         end

         if (replay_end_c) begin
            replay_valid <= 1'b0;
            replay_last  <= 1'b0;
         end
      end
   end

   assign bus.busy_o         = busy;
   assign bus.final_o        = final_q;
   assign bus.final_valid_o  = final_valid;
   assign bus.hidden_val_o   = hidden_val_q;
   assign bus.hidden_idx_o   = hidden_idx_q;
   assign bus.replay_valid_o = replay_valid;

endmodule

// File: doc/output_forward_mac.md
# output_forward_mac

Forward-pass accumulator for the output neuron. It consumes the hidden-layer activations and output weights as a serial stream and computes the output value `final_o = Σ hidden_val × w`. It keeps a copy of every hidden activation. When the backward pass starts, it replays those activations one per cycle, so the output backprop stage gets `final` and each `hidden_val` from a single source.

## Interface
- `N_HIDDEN`, default 4: number of hidden neurons per pass; legal range 2..32.
- `IDX_W`, default 2: index width; must equal ceil(log2(N_HIDDEN)).
- `clk_i` input 1: clock. All state changes on the rising edge.
- `rst_i` input 1: reset. Asynchronous, active-high. Clears all state.
- `start_i` input 1: begin a forward pass. Sampled in IDLE and DONE only.
- `valid_i` input 1: the current `hidden_val_i`/`w_i` beat is valid.
- `hidden_val_i` input 10: hidden activation, unsigned.
- `w_i` input 8: output weight paired with `hidden_val_i`, unsigned.
- `b_pass_i` input 1: backward pass request. Sampled in DONE only.
- `busy_o` output 1: high in ACCUM and REPLAY.
- `final_o` output 23: registered forward result, unsigned.
- `final_valid_o` output 1: `final_o` holds a completed sum.
- `hidden_val_o` output 10: replayed activation.
- `hidden_idx_o` output IDX_W: index of `hidden_val_o`.
- `replay_valid_o` output 1: `hidden_val_o`/`hidden_idx_o` are valid this cycle.

## Operation
- States: IDLE, ACCUM, DONE, REPLAY. State after reset is IDLE.
- **IDLE**
  - `start_i` → ACCUM. Clears `acc` and `idx`, and clears `final_valid_o`.
  - `b_pass_i` is ignored.
- **ACCUM**
  - Each cycle with `valid_i`=1:
    - `acc += hidden_val_i*w_i`, using an 18-bit product zero-extended to 23 bits.
    - `buf[idx] <= hidden_val_i`.
    - `idx++`.
  - A cycle with `valid_i`=0 is a bubble. No state changes.
  - On the beat where `idx == N_HIDDEN-1`: `final_o <= acc + product`, `final_valid_o <= 1`, `idx <= 0`, next state DONE.
  - `start_i` and `b_pass_i` are ignored.
- **DONE**
  - `final_o` and `final_valid_o` are held.
  - `b_pass_i` → REPLAY with `idx=0`.
  - `start_i` → ACCUM (new pass; same clearing as from IDLE).
  - If `start_i` and `b_pass_i` are both high, `b_pass_i` wins.
- **REPLAY**
  - Emits one entry per cycle, with no stall: `hidden_val_o <= buf[idx]`, `hidden_idx_o <= idx`, `replay_valid_o <= 1`.
  - After entry N_HIDDEN-1: next state IDLE and `replay_valid_o` drops.
  - `final_o`/`final_valid_o` are held through REPLAY and in IDLE afterwards. `final_valid_o` clears only on the next `start_i` or on reset.
  - All inputs are ignored in REPLAY.
- Arithmetic: worst case is 1023·255·32 = 8,347,680, which is below 2^23, so no overflow is possible and there is no saturation logic.
- `buf` is N_HIDDEN×10-bit registers, cleared by reset. It is not cleared by `start_i`; entries are overwritten as beats arrive.
- Outside REPLAY, `hidden_val_o` and `hidden_idx_o` hold their last value.
- Reset values (all outputs):
  - `busy_o`=0
  - `final_o`=0
  - `final_valid_o`=0
  - `hidden_val_o`=0
  - `hidden_idx_o`=0
  - `replay_valid_o`=0
- Reset mid-pass (ACCUM or REPLAY): returns to IDLE immediately, with all outputs at reset values. No partial result is ever presented.

## Timing
- `start_i` high at edge k: ACCUM from edge k, so `busy_o`=1 after edge k. The first beat can be accepted at edge k+1.
- Last valid beat accepted at edge m: `final_o` and `final_valid_o`=1 are visible after edge m, and `busy_o`=0 after edge m. Latency is 1 cycle from last beat to result.
- With no bubbles, a pass takes N_HIDDEN+1 edges from `start_i` to `final_valid_o`.
- `b_pass_i` at edge r:
  - entry 0 is visible after edge r+1;
  - entry i is visible after edge r+1+i;
  - `replay_valid_o` falls after edge r+1+N_HIDDEN.
- `busy_o`: 1 from edge r through r+N_HIDDEN inclusive, then 0.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- N_HIDDEN=4, hidden values {1,2,3,4}, weights {10,20,30,40}, back-to-back beats → `final_o`=300 and `final_valid_o`=1 one cycle after the 4th beat.
- Max operands 1023×255 on all 4 beats → `final_o`=1,043,460. Also run N_HIDDEN=32 all-max → `final_o`=8,347,680 with no wrap.
- Beats with bubbles (`valid_i` pattern 1,0,0,1,1,0,1), same data as the first test → `final_o`=300. `start_i` pulsed during ACCUM has no effect.
- From DONE, pulse `b_pass_i` → `hidden_val_o`/`hidden_idx_o` = (1,0),(2,1),(3,2),(4,3) on 4 consecutive cycles with `replay_valid_o`=1, then 0. `final_o` stays 300.
- Assert `rst_i` after 2 beats of a pass → all outputs 0 asynchronously. A fresh pass then gives the correct sum, unaffected by the partial accumulation.
- In DONE, assert `start_i` and `b_pass_i` together → REPLAY is entered. Then `start_i` from IDLE with new data {5,5,5,5}×{2,2,2,2} → `final_valid_o` drops, then `final_o`=40.
